// File: rtl/counter_axil_regs_if.sv
// AXI4-Lite slave bus bundle for the counter register block.
// master drives requests; slave returns readies and responses.
interface counter_axil_regs_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/counter_axil_regs.sv
// AXI4-Lite register block for the saturating counter: live COUNT, CTRL
// (clear/snapshot), SNAP and STATUS, plus a one-cycle user_reset pulse.
module counter_axil_regs #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     count_in,
  output logic                 user_reset,
  counter_axil_regs_if.slave   s_axi
);

  logic [ADDR_WIDTH-1:0] awaddr_w;
  logic [ADDR_WIDTH-1:0] araddr_w;
  logic                  aw_held;
  logic                  w_held;
  logic [1:0]            aw_sel_q;
  logic [1:0]            ctrl_q;
  logic                  strb0_q;
  logic [31:0]           snap;
  logic [31:0]           count_ext;
  logic [31:0]           rd_mux;
  logic                  saturated;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic                  ctrl_wr;
  logic                  unused_bits;

  assign awaddr_w  = s_axi.awaddr;
  assign araddr_w  = s_axi.araddr;
  assign count_ext = 32'(count_in);
  assign saturated = &count_in;

  // Readies are gated by reset so nothing is accepted while reset is held.
  assign s_axi.awready = !aw_held && !s_axi.bvalid && !reset;
  assign s_axi.wready  = !w_held  && !s_axi.bvalid && !reset;
  assign s_axi.arready = !s_axi.rvalid && !reset;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.rresp   = 2'b00;

  assign aw_hs   = s_axi.awvalid && s_axi.awready;
  assign w_hs    = s_axi.wvalid  && s_axi.wready;
  assign ar_hs   = s_axi.arvalid && s_axi.arready;
  assign commit  = aw_held && w_held && !s_axi.bvalid;
  assign ctrl_wr = (aw_sel_q == 2'b01) && strb0_q;

  assign unused_bits = ^{awaddr_w, araddr_w, s_axi.wdata, s_axi.wstrb};

  always_comb begin
    rd_mux = '0;
    case (araddr_w[3:2])
      2'b00:   rd_mux = count_ext;
      2'b01:   rd_mux = '0;
      2'b10:   rd_mux = snap;
      default: rd_mux = {31'b0, saturated};
    endcase
  end

  // Write path: AW and W latch independently, commit once both are held.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      s_axi.bvalid <= 1'b0;
      user_reset   <= 1'b0;
      snap         <= '0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_sel_q <= awaddr_w[3:2];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        ctrl_q  <= s_axi.wdata[1:0];
        strb0_q <= s_axi.wstrb[0];
      end
      // Snapshot samples on the commit edge, so it sees the pre-clear count.
      user_reset <= commit && ctrl_wr && ctrl_q[0];
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi.bvalid <= 1'b1;
        if (ctrl_wr && ctrl_q[1]) snap <= count_ext;
      end else if (s_axi.bvalid && s_axi.bready) begin
        s_axi.bvalid <= 1'b0;
      end
    end
  end

  // Read path: data captured on the AR handshake, held until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi.rvalid <= 1'b0;
      s_axi.rdata  <= '0;
    end else if (ar_hs) begin
      s_axi.rvalid <= 1'b1;
      s_axi.rdata  <= rd_mux;
    end else if (s_axi.rvalid && s_axi.rready) begin
      s_axi.rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_axil_regs.sv
// Directed bench for counter_axil_regs with a response scoreboard; a second
// instance with WIDTH=8 covers zero extension and saturation at narrow width.
module tb_counter_axil_regs;

  logic        clk;
  logic        reset;
  logic [31:0] count_in;
  logic        user_reset;
  logic [7:0]  count8;
  logic        user_reset8;

  int tests;
  int fails;
  int pulse_cnt;
  int p0;

  logic [31:0] rd_q[$];
  logic [1:0]  wr_q[$];

  counter_axil_regs_if #(.ADDR_WIDTH(4)) bus ();
  counter_axil_regs_if #(.ADDR_WIDTH(4)) bus8 ();

  counter_axil_regs #(.WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .user_reset (user_reset),
    .s_axi      (bus)
  );

  counter_axil_regs #(.WIDTH(8), .ADDR_WIDTH(4)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count8),
    .user_reset (user_reset8),
    .s_axi      (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (user_reset === 1'b1) pulse_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    rd_q.push_back(exp);
    chk({tag, "_arready"}, bus.arready, 1);
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
    @(negedge clk);
    chk({tag, "_rvalid"}, bus.rvalid, 1);
    if (bus.rvalid === 1'b1) begin
      chk(tag, bus.rdata, rd_q.pop_front());
      chk({tag, "_rresp"}, bus.rresp, 0);
    end else begin
      void'(rd_q.pop_front());
    end
  endtask

  task automatic axi_read8(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus8.araddr  = addr;
    bus8.arvalid = 1'b1;
    rd_q.push_back(exp);
    @(posedge clk);
    #1 bus8.arvalid = 1'b0;
    @(negedge clk);
    chk({tag, "_rvalid"}, bus8.rvalid, 1);
    if (bus8.rvalid === 1'b1) chk(tag, bus8.rdata, rd_q.pop_front());
    else void'(rd_q.pop_front());
  endtask

  // lead: 1 = W one cycle before AW, 0 = same cycle, -1 = AW first.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input bit wait_b, input logic exp_clr);
    bit   aw_done;
    bit   w_done;
    bit   found;
    logic awr;
    logic wr;
    aw_done = 1'b0;
    w_done  = 1'b0;
    found   = 1'b0;
    wr_q.push_back(2'b00);
    for (int cyc = 0; cyc < 10 && !(aw_done && w_done); cyc++) begin
      @(negedge clk);
      if (!aw_done && (lead <= 0 || cyc >= 1)) begin
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
      end
      if (!w_done && (lead >= 0 || cyc >= 1)) begin
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
      end
      awr = bus.awready;
      wr  = bus.wready;
      @(posedge clk);
      #1;
      if (bus.awvalid && awr) begin
        aw_done     = 1'b1;
        bus.awvalid = 1'b0;
      end
      if (bus.wvalid && wr) begin
        w_done     = 1'b1;
        bus.wvalid = 1'b0;
      end
    end
    chk("aw_w_handshake", {30'b0, aw_done, w_done}, 32'd3);
    if (wait_b) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (bus.bvalid === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      chk("bvalid_arrives", found, 1);
      if (found) begin
        chk("bresp", bus.bresp, wr_q.pop_front());
        chk("ureset_at_b", user_reset, exp_clr);
      end else begin
        void'(wr_q.pop_front());
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    pulse_cnt = 0;
    reset = 1'b1;
    count_in = '0;
    count8 = '0;
    bus.awaddr = '0;  bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    bus8.awaddr = '0; bus8.awvalid = 1'b0; bus8.wdata = '0; bus8.wstrb = '0; bus8.wvalid = 1'b0;
    bus8.bready = 1'b1; bus8.araddr = '0; bus8.arvalid = 1'b0; bus8.rready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_user_reset", user_reset, 0);
    reset = 1'b0;

    count_in = 32'h0000_1234;
    axi_read(4'h0, 32'h0000_1234, "rd_count");

    p0 = pulse_cnt;
    axi_write(4'h4, 32'h1, 4'hF, 1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("clear_pulse_cycles", pulse_cnt - p0, 1);
    axi_read(4'h4, 32'h0, "rd_ctrl_zero");

    count_in = 32'h0000_ABCD;
    p0 = pulse_cnt;
    axi_write(4'h4, 32'h3, 4'hF, 0, 1'b1, 1'b1);
    count_in = 32'h0000_0011;
    repeat (3) @(negedge clk);
    chk("snapclr_pulse_cycles", pulse_cnt - p0, 1);
    axi_read(4'h8, 32'h0000_ABCD, "rd_snap");

    p0 = pulse_cnt;
    axi_write(4'h4, 32'h1, 4'h0, -1, 1'b1, 1'b0);
    axi_write(4'h8, 32'h55, 4'hF, 0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("nostrb_no_pulse", pulse_cnt - p0, 0);
    axi_read(4'h8, 32'h0000_ABCD, "rd_snap_unchanged");

    count_in = 32'hFFFF_FFFF;
    axi_read(4'hC, 32'h1, "rd_status_sat");
    count_in = 32'h5;
    axi_read(4'hC, 32'h0, "rd_status_nosat");
    axi_read(4'h3, 32'h5, "rd_count_lowbits_ignored");

    count8 = 8'hFF;
    axi_read8(4'h0, 32'h0000_00FF, "rd8_count");
    axi_read8(4'hC, 32'h1, "rd8_status");

    count_in = 32'h77;
    bus.rready = 1'b0;
    @(negedge clk);
    bus.araddr  = 4'h0;
    bus.arvalid = 1'b1;
    rd_q.push_back(32'h77);
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
    count_in = 32'h99;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rvalid", bus.rvalid, 1);
      chk("bp_rdata", bus.rdata, rd_q[0]);
      chk("bp_arready", bus.arready, 0);
    end
    bus.rready = 1'b1;
    void'(rd_q.pop_front());
    @(negedge clk);
    chk("bp_rvalid_drop", bus.rvalid, 0);

    bus.bready = 1'b0;
    p0 = pulse_cnt;
    axi_write(4'h4, 32'h0, 4'hF, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("bhold_bvalid", bus.bvalid, 1);
    chk("bhold_awready", bus.awready, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_bvalid", bus.bvalid, 0);
    chk("midrst_awready", bus.awready, 0);
    chk("midrst_user_reset", user_reset, 0);
    reset = 1'b0;
    void'(wr_q.pop_front());
    bus.bready = 1'b1;
    @(negedge clk);
    chk("postrst_awready", bus.awready, 1);
    chk("postrst_bvalid", bus.bvalid, 0);
    axi_read(4'h8, 32'h0, "rd_snap_after_reset");
    chk("midrst_no_pulse", pulse_cnt - p0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_axil_regs.md
Name: counter_axil_regs

Overview:
AXI4-Lite slave register block that sits directly downstream of the free-running saturating counter and drives its user_reset input. Software uses it to read the live count, take an atomic snapshot, check saturation, and issue a one-cycle clear pulse back to the counter. There is one slave port, with single-beat transactions only and no outstanding-transaction queue.

Parameters:
WIDTH, 32, counter width in bits (1..32); count_in is zero-extended to 32 bits on reads.
ADDR_WIDTH, 4, AXI address width; only addr[3:2] is decoded and lower bits are ignored.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
count_in  in  WIDTH  counter value from the upstream counter.
user_reset  out  1  one-cycle active-high clear pulse to the counter.
s_axi_awaddr  in  ADDR_WIDTH  write address.
s_axi_awvalid  in  1  write address valid.
s_axi_awready  out  1  write address ready.
s_axi_wdata  in  32  write data.
s_axi_wstrb  in  4  write byte strobes.
s_axi_wvalid  in  1  write data valid.
s_axi_wready  out  1  write data ready.
s_axi_bresp  out  2  write response; always 2'b00.
s_axi_bvalid  out  1  write response valid.
s_axi_bready  in  1  write response ready.
s_axi_araddr  in  ADDR_WIDTH  read address.
s_axi_arvalid  in  1  read address valid.
s_axi_arready  out  1  read address ready.
s_axi_rdata  out  32  read data.
s_axi_rresp  out  2  read response; always 2'b00.
s_axi_rvalid  out  1  read data valid.
s_axi_rready  in  1  read data ready.

Behaviour:
- Reset: while reset=1, force the following on the next edge.
  - awready=wready=arready=0, bvalid=rvalid=0, rdata=0, user_reset=0, SNAP=0.
  - Drop the aw_held and w_held flags.
  - Readies may rise on the first cycle after reset deasserts.
- Register map, decoded by addr[3:2]:
  - 0x0 COUNT (RO): zero-extended count_in, sampled at the AR handshake cycle.
  - 0x4 CTRL (WO, reads 0): bit0=1 requests a clear; bit1=1 requests a snapshot. Only acts when wstrb[0]=1.
  - 0x8 SNAP (RO): snapshot register, zero-extended.
  - 0xC STATUS (RO): bit0 = (count_in == all ones), i.e. saturated; other bits 0.
  - Writes to RO addresses are accepted with OKAY and have no effect.
- Write channel:
  - awready = !aw_held && !bvalid. wready = !w_held && !bvalid.
  - AW and W may arrive in either order or in the same cycle; each is latched on its handshake.
  - Commit happens in the first cycle where both are held and bvalid=0.
  - On that commit edge: apply the register effect, set bvalid=1, and clear both held flags.
  - bvalid holds until the bready handshake.
  - Minimum AW/W-to-B latency is 1 cycle.
- CTRL effects:
  - Clear: user_reset=1 for exactly the one cycle after the commit edge, then 0.
  - Snapshot: SNAP <= count_in on the commit edge.
  - Both bits set in one write: SNAP captures the pre-clear value, because the pulse follows the commit.
- Read channel:
  - arready = !rvalid.
  - On the AR handshake: rdata <= selected value, rvalid <= 1 on the same edge, giving 1-cycle latency.
  - rdata and rvalid hold stable until the rready handshake.
  - One read is outstanding at a time.
- Concurrency:
  - Read and write paths are independent and may handshake in the same cycle.
  - A SNAP read whose AR handshake coincides with a snapshot commit returns the old SNAP.
- Backpressure: with bready=0 or rready=0 held indefinitely, the respective valid and data hold and no new handshakes occur on that channel.
- Reset mid-transaction: any pending B/R response or held AW/W is discarded and never answered.

Test Plan:
- Read 0x0 with count_in=32'h0000_1234 and rready=1 -> arready=1 at request; next cycle rvalid=1, rdata=32'h0000_1234, rresp=0.
- Write 0x4 with wdata=1, wstrb=4'hF, W one cycle before AW -> bvalid one cycle after AW; user_reset high exactly 1 cycle; bresp=0.
- count_in=32'hABCD, write 0x4 with data=3 -> SNAP reads 32'hABCD; user_reset pulses once after the commit edge.
- Write 0x4 with data=1, wstrb=4'h0 -> OKAY response, no user_reset pulse; write to 0x8 -> SNAP unchanged.
- count_in=all ones, read 0xC -> rdata=1; count_in=5 -> rdata=0; WIDTH=8, count_in=8'hFF -> 0x0 reads 32'h0000_00FF and STATUS=1.
- Hold rready=0 for 10 cycles after an AR -> rvalid and rdata stable, arready=0. Assert reset with bvalid=1 -> bvalid=0 next cycle and no pulse is issued.
